// File: rtl/f2i_arbiter_if.sv
// ---------------------------------------------------------------------------
// f2i_arbiter_if
// Bundles the request, shared-converter and response signals of the
// f2i_arbiter.
//   slave  : the arbiter side (takes requests and converter result,
//            drives grants, converter operand and the response).
//   master : the environment side (requesters, converter, consumer).
// Signals:
//   i_req_valid    per-requester request valid
//   i_req_float    packed operands, requester n at [32n+31:32n]
//   o_req_ready    one-hot grant/accept
//   o_conv_float   operand presented to the shared f2i converter
//   i_conv_integer result from the shared f2i converter
//   o_rsp_valid / i_rsp_ready   response handshake
//   o_rsp_integer  corrected unsigned magnitude
//   o_rsp_id       originating requester index
//   o_rsp_sign     operand sign bit
//   o_rsp_ovf      operand magnitude >= 65536.0
//   o_busy         an operation is in flight
// ---------------------------------------------------------------------------
interface f2i_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) ();
    logic [NUM_REQ-1:0]    i_req_valid;
    logic [32*NUM_REQ-1:0] i_req_float;
    logic [NUM_REQ-1:0]    o_req_ready;
    logic [31:0]           o_conv_float;
    logic [15:0]           i_conv_integer;
    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [15:0]           o_rsp_integer;
    logic [ID_W-1:0]       o_rsp_id;
    logic                  o_rsp_sign;
    logic                  o_rsp_ovf;
    logic                  o_busy;

    modport slave (
        input  i_req_valid, i_req_float, i_conv_integer, i_rsp_ready,
        output o_req_ready, o_conv_float, o_rsp_valid, o_rsp_integer,
               o_rsp_id, o_rsp_sign, o_rsp_ovf, o_busy
    );

    modport master (
        output i_req_valid, i_req_float, i_conv_integer, i_rsp_ready,
        input  o_req_ready, o_conv_float, o_rsp_valid, o_rsp_integer,
               o_rsp_id, o_rsp_sign, o_rsp_ovf, o_busy
    );
endinterface

// File: rtl/f2i_arbiter.sv
// ---------------------------------------------------------------------------
// f2i_arbiter
// Round-robin arbiter/sequencer sharing one combinational f2i converter
// between NUM_REQ requesters. An accepted operand is registered and driven to
// the converter for one cycle (CONV); the converter result is then captured,
// range-corrected by exponent and returned with the requester ID (RESP).
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      f2i_arbiter_if.slave (requests, converter link, response)
// ---------------------------------------------------------------------------
module f2i_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    f2i_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_q;          // last granted index, also in-flight ID
    logic [31:0]     op_q;            // operand register feeding the converter
    logic [15:0]     rsp_int_q;
    logic [ID_W-1:0] rsp_id_q;
    logic            rsp_sign_q;
    logic            rsp_ovf_q;

    logic [31:0]        req_float_w [NUM_REQ];
    logic               window;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic [31:0]        grant_float;
    logic [7:0]         exp_w;
    logic [15:0]        res_int;
    logic               res_ovf;

    // Unpack the flat operand bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_float_w[gi] = bus.i_req_float[32*gi +: 32];
        end
    endgenerate

    // Grants are possible when idle, or when the pending response is being
    // consumed this cycle. Reset forces every grant low immediately.
    assign window = i_rst_n &&
                    ((state_q == IDLE) || ((state_q == RESP) && bus.i_rsp_ready));

    // Round-robin: first pass covers indices above the last grant, second
    // pass wraps around to indices at or below it.
    always_comb begin
        grant_any   = 1'b0;
        grant_oh    = '0;
        grant_idx   = '0;
        grant_float = '0;
        if (window) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && (i > int'(last_q)) && bus.i_req_valid[i]) begin
                    grant_any   = 1'b1;
                    grant_oh[i] = 1'b1;
                    grant_idx   = ID_W'(i);
                    grant_float = req_float_w[i];
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_any && (i <= int'(last_q)) && bus.i_req_valid[i]) begin
                    grant_any   = 1'b1;
                    grant_oh[i] = 1'b1;
                    grant_idx   = ID_W'(i);
                    grant_float = req_float_w[i];
                end
            end
        end
    end

    // Range correction: below 1.0 the result is 0, from 2^16 upward (and
    // Inf/NaN) it saturates and flags overflow; otherwise trust the converter.
    assign exp_w = op_q[30:23];
    always_comb begin
        res_int = bus.i_conv_integer;
        res_ovf = 1'b0;
        if (exp_w < 8'd127) begin
            res_int = 16'h0000;
        end else if (exp_w >= 8'd143) begin
            res_int = 16'hFFFF;
            res_ovf = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant_any) state_d = CONV;
            CONV: state_d = RESP;
            RESP: if (bus.i_rsp_ready) state_d = grant_any ? CONV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            last_q     <= ID_W'(NUM_REQ - 1);
            op_q       <= '0;
            rsp_int_q  <= '0;
            rsp_id_q   <= '0;
            rsp_sign_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                op_q   <= grant_float;
                last_q <= grant_idx;
            end
            if (state_q == CONV) begin
                rsp_int_q  <= res_int;
                rsp_ovf_q  <= res_ovf;
                rsp_sign_q <= op_q[31];
                rsp_id_q   <= last_q;
            end
        end
    end

    assign bus.o_req_ready   = grant_oh;
    assign bus.o_conv_float  = op_q;
    assign bus.o_rsp_valid   = (state_q == RESP);
    assign bus.o_rsp_integer = rsp_int_q;
    assign bus.o_rsp_id      = rsp_id_q;
    assign bus.o_rsp_sign    = rsp_sign_q;
    assign bus.o_rsp_ovf     = rsp_ovf_q;
    assign bus.o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_f2i_arbiter.sv
// ---------------------------------------------------------------------------
// tb_f2i_arbiter
// Directed bench for f2i_arbiter. A behavioural f2i converter feeds the DUT
// (returning junk outside its valid exponent range so the DUT's clamping is
// exercised). Expected responses are pushed to a queue on each accept and
// compared while the DUT presents them.
// ---------------------------------------------------------------------------
module tb_f2i_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] val;
        logic        sign;
        logic        ovf;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    f2i_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    f2i_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural shared converter: truncating float magnitude to integer.
    logic [15:0] conv_w;
    always_comb begin
        int          e;
        logic [23:0] mant;
        e    = int'(bus.o_conv_float[30:23]);
        mant = {1'b1, bus.o_conv_float[22:0]};
        if (e >= 127 && e <= 142) conv_w = 16'(mant >> (150 - e));
        else                      conv_w = 16'hDEAD;
    end
    assign bus.i_conv_integer = conv_w;

    // Reference state for expected grants/responses.
    int   m_state;   // 0 idle, 1 conv, 2 resp
    int   m_last;
    rsp_t sb [$];
    rsp_t exp_tab [NUM_REQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int n, input logic [31:0] f, input logic [15:0] v,
                           input logic s, input logic o);
        bus.i_req_float[32*n +: 32] = f;
        bus.i_req_valid[n]          = 1'b1;
        exp_tab[n].id   = 2'(n);
        exp_tab[n].val  = v;
        exp_tab[n].sign = s;
        exp_tab[n].ovf  = o;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_last  = NUM_REQ - 1;
        sb.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.o_req_ready), 32'd0);
        chk({tag, "_conv"},  bus.o_conv_float, 32'd0);
        chk({tag, "_valid"}, 32'(bus.o_rsp_valid), 32'd0);
        chk({tag, "_int"},   32'(bus.o_rsp_integer), 32'd0);
        chk({tag, "_id"},    32'(bus.o_rsp_id), 32'd0);
        chk({tag, "_sign"},  32'(bus.o_rsp_sign), 32'd0);
        chk({tag, "_ovf"},   32'(bus.o_rsp_ovf), 32'd0);
        chk({tag, "_busy"},  32'(bus.o_busy), 32'd0);
    endtask

    // One clock cycle: check current outputs against the reference, update the
    // reference for the coming edge, then advance to 1 time unit past the edge.
    task automatic step();
        logic [NUM_REQ-1:0] exp_rdy;
        int                 gidx;
        #1;
        exp_rdy = '0;
        gidx    = -1;
        if (rst_n && (m_state == 0 || (m_state == 2 && bus.i_rsp_ready))) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int idx;
                idx = (m_last + k) % NUM_REQ;
                if (gidx < 0 && bus.i_req_valid[idx]) gidx = idx;
            end
        end
        if (gidx >= 0) exp_rdy[gidx] = 1'b1;
        chk("req_ready", 32'(bus.o_req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(m_state == 2));
        chk("busy",      32'(bus.o_busy),      32'(m_state != 0));
        if (m_state == 2) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                chk("rsp_int",  32'(bus.o_rsp_integer), 32'(sb[0].val));
                chk("rsp_id",   32'(bus.o_rsp_id),      32'(sb[0].id));
                chk("rsp_sign", 32'(bus.o_rsp_sign),    32'(sb[0].sign));
                chk("rsp_ovf",  32'(bus.o_rsp_ovf),     32'(sb[0].ovf));
                if (bus.i_rsp_ready) begin
                    $display("rsp id=%0d int=%h sign=%0d ovf=%0d",
                             bus.o_rsp_id, bus.o_rsp_integer, bus.o_rsp_sign, bus.o_rsp_ovf);
                    void'(sb.pop_front());
                end
            end
        end
        if (rst_n) begin
            case (m_state)
                0: if (gidx >= 0) m_state = 1;
                1: m_state = 2;
                default: if (bus.i_rsp_ready) m_state = (gidx >= 0) ? 1 : 0;
            endcase
            if (gidx >= 0) begin
                sb.push_back(exp_tab[gidx]);
                m_last = gidx;
                $display("accept req=%0d float=%h", gidx, bus.i_req_float[32*gidx +: 32]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single request on requester n, held until accepted, then drained.
    task automatic run_one(input int n, input logic [31:0] f, input logic [15:0] v,
                           input logic s, input logic o);
        set_req(n, f, v, s, o);
        step();
        bus.i_req_valid[n] = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_float = '0;
        bus.i_rsp_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Single request: response valid two cycles after accept.
        run_one(0, 32'h42C80000, 16'd100, 1'b0, 1'b0);

        // Exponent range handling.
        run_one(0, 32'h3F800000, 16'd1,    1'b0, 1'b0);
        run_one(0, 32'h477FFF00, 16'hFFFF, 1'b0, 1'b0);
        run_one(0, 32'h47800000, 16'hFFFF, 1'b0, 1'b1);
        run_one(0, 32'h3F000000, 16'd0,    1'b0, 1'b0);
        run_one(0, 32'h00000000, 16'd0,    1'b0, 1'b0);
        run_one(3, 32'hC0400000, 16'd3,    1'b1, 1'b0);
        run_one(2, 32'h7F800000, 16'hFFFF, 1'b0, 1'b1);
        run_one(3, 32'hC0400000, 16'd3,    1'b1, 1'b0);

        // Round robin with all requesters continuously valid: 0,1,2,3,0.
        set_req(0, 32'h3F800000, 16'd1, 1'b0, 1'b0);
        set_req(1, 32'h40000000, 16'd2, 1'b0, 1'b0);
        set_req(2, 32'h40400000, 16'd3, 1'b0, 1'b0);
        set_req(3, 32'h40800000, 16'd4, 1'b0, 1'b0);
        repeat (10) step();
        chk("rr_last", 32'(m_last), 32'd0);
        bus.i_req_valid = '0;
        repeat (3) step();

        // Backpressure: response held, no grants while the consumer stalls.
        set_req(0, 32'h3F800000, 16'd1, 1'b0, 1'b0);
        step();
        bus.i_req_valid[0] = 1'b0;
        step();
        bus.i_rsp_ready = 1'b0;
        set_req(1, 32'h40000000, 16'd2, 1'b0, 1'b0);
        repeat (5) step();
        bus.i_rsp_ready = 1'b1;
        #1;
        chk("bp_grant", 32'(bus.o_req_ready), 32'h2);
        step();
        bus.i_req_valid[1] = 1'b0;
        repeat (3) step();

        // Reset while in CONV: outputs clear, in-flight result is dropped.
        set_req(1, 32'h40400000, 16'd3, 1'b0, 1'b0);
        step();
        bus.i_req_valid[1] = 1'b0;
        set_req(0, 32'h40800000, 16'd4, 1'b0, 1'b0);
        set_req(2, 32'h40A00000, 16'd5, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(bus.o_req_ready), 32'h1);
        step();
        bus.i_req_valid[0] = 1'b0;
        step();
        step();
        bus.i_req_valid[2] = 1'b0;
        repeat (4) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
